// File: rtl/sr_row_feeder.sv
// sr_row_feeder: turns a raster pixel stream into row loads plus column shifts
// for a DEPTH-byte shift-register window.
module sr_row_feeder #(
    parameter int DEPTH      = 3,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 sr_enable,
    output logic                 sr_shift_row_up,
    output logic [7:0]           sr_column_shift_in,
    output logic [8*DEPTH-1:0]   sr_row_shift_in,
    output logic                 win_valid,
    output logic                 row_done,
    output logic                 frame_done
);
    localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, GATHER, LOAD, STREAM} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic [8*DEPTH-1:0] staging;
    logic               last_col, last_row, row_end;

    always_comb begin
        in_ready           = state == GATHER || state == STREAM;
        sr_enable          = state == LOAD || (state == STREAM && in_valid);
        sr_shift_row_up    = state == LOAD;
        sr_column_shift_in = state == STREAM ? in_data : 8'd0;
        sr_row_shift_in    = staging;
        last_col           = col == CW'(IMG_WIDTH - 1);
        last_row           = row == RW'(IMG_HEIGHT - 1);
        row_end            = (state == LOAD && IMG_WIDTH == DEPTH) ||
                             (state == STREAM && in_valid && last_col);
        state_nxt          = state;
        case (state)
            IDLE:    state_nxt = start ? GATHER : IDLE;
            GATHER:  state_nxt = (in_valid && col == CW'(DEPTH - 1)) ? LOAD : GATHER;
            LOAD:    state_nxt = IMG_WIDTH > DEPTH ? STREAM : (last_row ? IDLE : GATHER);
            STREAM:  state_nxt = row_end ? (last_row ? IDLE : GATHER) : STREAM;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // The column counter holds at its limit when the last gather pixel is also the
    // last pixel of the row; the LOAD row end then clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col     <= '0;
            row     <= '0;
            staging <= '0;
        end else begin
            if (state == IDLE && start) begin
                col <= '0;
                row <= '0;
            end else if (row_end) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else if (in_ready && in_valid && !last_col) begin
                col <= col + 1'b1;
            end
            for (int i = 0; i < DEPTH; i++)
                if (state == GATHER && in_valid && col == CW'(i))
                    staging[8*(DEPTH-1-i) +: 8] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_valid  <= 1'b0;
            row_done   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= sr_enable;
            row_done   <= row_end;
            frame_done <= row_end && last_row;
        end
    end
endmodule

// File: tb/tb_sr_row_feeder.sv
// tb_sr_row_feeder: randomized frames checked against a pixel-list model of the
// expected row loads, column shifts and pulse counts.
module tb_sr_row_feeder;
    localparam int D = 3, W = 5, H = 2;
    localparam int DB = 4, WB = 4, HB = 1;

    logic clock = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic in_ready, sr_enable, sr_shift_row_up, win_valid, row_done, frame_done;
    logic [7:0] sr_column_shift_in;
    logic [8*D-1:0] sr_row_shift_in;

    logic start_b = 1'b0, in_valid_b = 1'b0;
    logic [7:0] in_data_b = 8'd0;
    logic in_ready_b, sr_enable_b, sr_shift_row_up_b, win_valid_b, row_done_b, frame_done_b;
    logic [7:0] sr_column_shift_in_b;
    logic [8*DB-1:0] sr_row_shift_in_b;

    int vec = 0, errs = 0;
    logic [8*D-1:0] load_q[$];
    logic [7:0] shift_q[$];
    int win_cnt = 0, row_cnt = 0, frame_cnt = 0;
    bit prev_en = 1'b0;

    sr_row_feeder #(.DEPTH(D), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clock(clock), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sr_enable(sr_enable), .sr_shift_row_up(sr_shift_row_up),
        .sr_column_shift_in(sr_column_shift_in), .sr_row_shift_in(sr_row_shift_in),
        .win_valid(win_valid), .row_done(row_done), .frame_done(frame_done)
    );

    sr_row_feeder #(.DEPTH(DB), .IMG_WIDTH(WB), .IMG_HEIGHT(HB)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .sr_enable(sr_enable_b), .sr_shift_row_up(sr_shift_row_up_b),
        .sr_column_shift_in(sr_column_shift_in_b), .sr_row_shift_in(sr_row_shift_in_b),
        .win_valid(win_valid_b), .row_done(row_done_b), .frame_done(frame_done_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs_a();
        return {in_ready, sr_enable, sr_shift_row_up, win_valid, row_done, frame_done,
                sr_column_shift_in, sr_row_shift_in};
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            prev_en = 1'b0;
        end else begin
            check("win_valid_follows_enable", win_valid, prev_en);
            if (sr_shift_row_up) begin
                check("load_enable_not_ready", {sr_enable, in_ready}, 2'b10);
                load_q.push_back(sr_row_shift_in);
            end else if (sr_enable) begin
                check("shift_only_on_transfer", in_valid && in_ready, 1);
                shift_q.push_back(sr_column_shift_in);
            end
            if (win_valid) win_cnt++;
            if (row_done) begin
                row_cnt++;
                check("row_done_shift_count", shift_q.size(), row_cnt * (W - D));
                check("row_done_load_count", load_q.size(), row_cnt);
            end
            if (frame_done) begin
                frame_cnt++;
                check("frame_done_with_last_row", {row_done, row_cnt == H}, 2'b11);
            end
            prev_en = sr_enable;
        end
    end

    task automatic run_frame(input bit directed, input bit gaps, input bit extra_start,
                             input int abort_after);
        logic [7:0] pix[W*H];
        logic [8*D-1:0] bus;
        int idx, nstream, cyc, k;
        bit xfer;
        for (int i = 0; i < W*H; i++) pix[i] = directed ? 8'(i + 1) : 8'($urandom);
        load_q.delete();
        shift_q.delete();
        win_cnt = 0; row_cnt = 0; frame_cnt = 0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        idx = 0; nstream = 0; cyc = 0;
        while (idx < W*H && cyc < 500) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? pix[idx] : 8'($urandom);
            start    = extra_start && $urandom_range(0, 3) == 0;
            @(negedge clock);
            xfer = in_valid && in_ready;
            @(posedge clock); #1;
            cyc++;
            if (xfer) begin
                if (idx % W >= D) nstream++;
                idx++;
            end
            if (abort_after != 0 && nstream == abort_after) begin
                reset = 1'b1;
                #1;
                check("abort_outputs_zero", outs_a(), 0);
                start = 1'b1;
                in_valid = 1'b1;
                in_data = 8'($urandom);
                repeat (2) @(posedge clock);
                #1;
                check("abort_held_outputs_zero", outs_a(), 0);
                reset = 1'b0;
                start = 1'b0;
                repeat (4) begin
                    in_valid = 1'($urandom_range(0, 1));
                    @(posedge clock); #1;
                    check("post_abort_quiet", {in_ready, sr_enable}, 0);
                end
                in_valid = 1'b0;
                return;
            end
        end
        check("frame_pixel_budget", idx, W*H);
        in_valid = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("load_count", load_q.size(), H);
        for (int r = 0; r < H && r < load_q.size(); r++) begin
            bus = '0;
            for (int c = 0; c < D; c++) bus = {bus[8*D-9:0], pix[r*W+c]};
            check("load_bus", load_q[r], bus);
        end
        check("shift_count", shift_q.size(), H * (W - D));
        k = 0;
        for (int r = 0; r < H; r++)
            for (int c = D; c < W; c++) begin
                if (k < shift_q.size()) check("shift_byte", shift_q[k], pix[r*W+c]);
                k++;
            end
        check("win_count", win_cnt, H * (W - D + 1));
        check("row_count", row_cnt, H);
        check("frame_count", frame_cnt, 1);
        check("idle_after_frame", {in_ready, sr_enable}, 0);
    endtask

    initial begin
        repeat (5) begin
            start = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            @(posedge clock); #1;
            check("reset_outputs_zero", outs_a(), 0);
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (5) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            @(posedge clock); #1;
            check("no_activity_before_start", outs_a() >> (8 + 8*D), 0);
        end
        in_valid = 1'b0;
        run_frame(1'b1, 1'b0, 1'b0, 0);
        run_frame(1'b1, 1'b1, 1'b0, 0);
        run_frame(1'b0, 1'b0, 1'b0, 2);
        run_frame(1'b1, 1'b0, 1'b0, 0);
        run_frame(1'b0, 1'b1, 1'b1, 0);
        repeat (3) run_frame(1'b0, 1'b1, 1'b0, 0);

        start_b = 1'b1;
        @(posedge clock); #1;
        start_b = 1'b0;
        in_valid_b = 1'b1;
        for (int i = 0; i < WB; i++) begin
            in_data_b = 8'(i + 1);
            check("b_gather_ready", {in_ready_b, sr_enable_b}, 2'b10);
            @(posedge clock); #1;
        end
        in_valid_b = 1'b0;
        check("b_load_controls", {in_ready_b, sr_enable_b, sr_shift_row_up_b}, 3'b011);
        check("b_load_bus", sr_row_shift_in_b, 32'h01020304);
        @(posedge clock); #1;
        check("b_row_end_pulses", {win_valid_b, row_done_b, frame_done_b, in_ready_b, sr_enable_b}, 5'b11100);
        @(posedge clock); #1;
        check("b_quiet_after", {win_valid_b, row_done_b, frame_done_b, in_ready_b, sr_enable_b}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
